// File: rtl/clock_pkg.sv
// Shared time-of-day widths, limits and alarm state encodings for the 1 Hz clock domain.
package clock_pkg;

  localparam int HOUR_W   = 5;
  localparam int MINSEC_W = 6;

  localparam int HOUR_MAX = 23;
  localparam int MIN_MAX  = 59;
  localparam int SEC_MAX  = 59;

  typedef logic [2:0] state_t;

  localparam state_t ST_DISARMED = 3'd0;
  localparam state_t ST_ARMED    = 3'd1;
  localparam state_t ST_SET      = 3'd2;
  localparam state_t ST_RINGING  = 3'd3;
  localparam state_t ST_SNOOZE   = 3'd4;

  function automatic logic [HOUR_W-1:0] hour_inc(input logic [HOUR_W-1:0] h);
    return (h == HOUR_W'(HOUR_MAX)) ? '0 : h + HOUR_W'(1);
  endfunction

  function automatic logic [MINSEC_W-1:0] min_inc(input logic [MINSEC_W-1:0] m);
    return (m == MINSEC_W'(MIN_MAX)) ? '0 : m + MINSEC_W'(1);
  endfunction

endpackage

// File: rtl/alarm_controller_if.sv
// Alarm controller I/O bundle: switch/button levels and clock time in, alarm status out.
interface alarm_controller_if;
  import clock_pkg::*;

  logic                set_alarm;
  logic                alarm_en;
  logic                hour_in;
  logic                min_in;
  logic                snooze_in;
  logic                dismiss_in;
  logic [HOUR_W-1:0]   cur_hour;
  logic [MINSEC_W-1:0] cur_min;
  logic [MINSEC_W-1:0] cur_sec;

  logic [HOUR_W-1:0]   alarm_hour;
  logic [MINSEC_W-1:0] alarm_min;
  logic                ringing;
  logic                snooze_active;
  logic [2:0]          state_out;
  logic                chime;

  modport master (
    output set_alarm, alarm_en, hour_in, min_in, snooze_in, dismiss_in,
    output cur_hour, cur_min, cur_sec,
    input  alarm_hour, alarm_min, ringing, snooze_active, state_out, chime
  );

  modport slave (
    input  set_alarm, alarm_en, hour_in, min_in, snooze_in, dismiss_in,
    input  cur_hour, cur_min, cur_sec,
    output alarm_hour, alarm_min, ringing, snooze_active, state_out, chime
  );

endinterface

// File: rtl/alarm_countdown.sv
// alarm_countdown: 9-bit loadable down-counter shared by ring and snooze intervals.
// Latency: load/dec take effect on the next clk_1Hz edge; no backpressure, load beats dec.
module alarm_countdown (
  input  logic       clk_1Hz,
  input  logic       resetn,
  input  logic       load,
  input  logic [8:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [8:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec) begin
      cnt_d = cnt_q - 9'd1;
    end
  end

  always_ff @(posedge clk_1Hz or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == 9'd0);

endmodule

// File: rtl/alarm_controller.sv
// alarm_controller: alarm set/arm/ring/snooze sequencer; outputs decoded from registers, 1-cycle latency.
// No backpressure: levels sampled every clk_1Hz edge. Optional hourly chime under CLOCK_CHIME_EN.
module alarm_controller
  import clock_pkg::*;
#(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input logic               clk_1Hz,
  input logic               resetn,
  alarm_controller_if.slave io
);

  localparam logic [8:0] RING_LOAD   = 9'(RING_SECS - 1);
  localparam logic [8:0] SNOOZE_LOAD = 9'(SNOOZE_SECS - 1);
  localparam logic [7:0] SNZ_LIMIT   = 8'(MAX_SNOOZE);

  state_t              state_q, state_d;
  logic [HOUR_W-1:0]   alarm_hour_q, alarm_hour_d;
  logic [MINSEC_W-1:0] alarm_min_q, alarm_min_d;
  logic [7:0]          snooze_cnt_q, snooze_cnt_d;

  logic       cnt_load;
  logic [8:0] cnt_val;
  logic       cnt_dec;
  logic       cnt_zero;
  logic       time_match;

  alarm_countdown u_countdown (
    .clk_1Hz  (clk_1Hz),
    .resetn   (resetn),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign time_match = (io.cur_hour == alarm_hour_q) &&
                      (io.cur_min  == alarm_min_q)  &&
                      (io.cur_sec  == '0);

  always_comb begin
    state_d      = state_q;
    alarm_hour_d = alarm_hour_q;
    alarm_min_d  = alarm_min_q;
    snooze_cnt_d = snooze_cnt_q;
    cnt_load     = 1'b0;
    cnt_val      = RING_LOAD;
    cnt_dec      = 1'b0;

    // Adjust buttons act on the registered state, so the cycle that enters SET ignores them.
    if (state_q == ST_SET) begin
      if (io.hour_in) alarm_hour_d = hour_inc(alarm_hour_q);
      if (io.min_in)  alarm_min_d  = min_inc(alarm_min_q);
    end

    if (io.set_alarm) begin
      state_d = ST_SET;
    end else if (!io.alarm_en) begin
      state_d = ST_DISARMED;
    end else begin
      case (state_q)
        ST_DISARMED, ST_SET: state_d = ST_ARMED;
        ST_ARMED: begin
          if (time_match) begin
            state_d      = ST_RINGING;
            cnt_load     = 1'b1;
            cnt_val      = RING_LOAD;
            snooze_cnt_d = '0;
          end
        end
        ST_RINGING: begin
          if (io.dismiss_in) begin
            state_d = ST_ARMED;
          end else if (io.snooze_in && (snooze_cnt_q < SNZ_LIMIT)) begin
            state_d      = ST_SNOOZE;
            snooze_cnt_d = snooze_cnt_q + 8'd1;
            cnt_load     = 1'b1;
            cnt_val      = SNOOZE_LOAD;
          end else if (cnt_zero) begin
            state_d = ST_ARMED;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        ST_SNOOZE: begin
          if (io.dismiss_in) begin
            state_d = ST_ARMED;
          end else if (cnt_zero) begin
            state_d  = ST_RINGING;
            cnt_load = 1'b1;
            cnt_val  = RING_LOAD;
          end else begin
            cnt_dec = 1'b1;
          end
        end
        default: state_d = ST_DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk_1Hz or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_DISARMED;
      alarm_hour_q <= '0;
      alarm_min_q  <= '0;
      snooze_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      alarm_hour_q <= alarm_hour_d;
      alarm_min_q  <= alarm_min_d;
      snooze_cnt_q <= snooze_cnt_d;
    end
  end

`ifdef CLOCK_CHIME_EN
  logic chime_q, chime_d;

  always_comb begin
    chime_d = (io.cur_min == '0) && (io.cur_sec == '0) &&
              (state_q != ST_RINGING) && (state_q != ST_SNOOZE);
  end

  always_ff @(posedge clk_1Hz or negedge resetn) begin
    if (!resetn) begin
      chime_q <= 1'b0;
    end else begin
      chime_q <= chime_d;
    end
  end

  assign io.chime = chime_q;
`else
  assign io.chime = 1'b0;
`endif

  assign io.alarm_hour    = alarm_hour_q;
  assign io.alarm_min     = alarm_min_q;
  assign io.ringing       = (state_q == ST_RINGING);
  assign io.snooze_active = (state_q == ST_SNOOZE);
  assign io.state_out     = state_q;

endmodule
